// File: rtl/angle_conv_pkg.sv
// Shared types and width helpers for the angle-to-pulse converter.
package angle_conv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StDiv,
    StDone
  } conv_state_e;

  // Product width: angle bits plus enough bits to hold the multiplier constant.
  function automatic int unsigned prod_width(input int unsigned deg_w,
                                             input int unsigned scale_num);
    return deg_w + $clog2(scale_num + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per cycle, WIDTH cycles after start.
module seq_divider #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DIV_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DIV_W:0]   trial;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // quo_q doubles as the dividend shift register: MSBs leave as quotient bits enter.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q, quo_q[WIDTH-1]};
    if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      cnt_d  = CNT_W'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, divisor_i}) begin
        rem_d = DIV_W'(trial - {1'b0, divisor_i});
        quo_d = (quo_q << 1) | WIDTH'(1);
      end else begin
        rem_d = trial[DIV_W-1:0];
        quo_d = quo_q << 1;
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end
    end
  end

  assign done_o     = busy_q && (cnt_q == '0);
  assign quotient_o = quo_q;

endmodule

// File: rtl/angle_to_pulse_conv.sv
// Servo angle to pulse-cycle converter: clamp, multiply, sequential divide, per-channel store.
// Define ANGLE_CONV_ROUND_EN to round half-up instead of truncating.
module angle_to_pulse_conv
  import angle_conv_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DEG_W     = 9,
  parameter int unsigned CYC_W     = 10,
  parameter int unsigned SCALE_NUM = 10,
  parameter int unsigned SCALE_DEN = 18,
  parameter int unsigned MAX_DEG   = 180,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      in_Clk,
  input  logic                      in_Rst,
  input  logic                      in_Valid,
  output logic                      out_Ready,
  input  logic [CH_W-1:0]           in_Channel,
  input  logic [DEG_W-1:0]          in_Degrees,
  output logic                      out_Valid,
  input  logic                      in_Ready,
  output logic [CH_W-1:0]           out_Channel,
  output logic [CYC_W-1:0]          out_Cycles,
  output logic                      out_Clamped,
  output logic [CHANNELS*CYC_W-1:0] out_Cycles_All
);

  localparam int unsigned PROD_W = prod_width(DEG_W, SCALE_NUM);
  localparam int unsigned DEN_W  = $clog2(SCALE_DEN + 1);

  if (SCALE_DEN == 0 || CHANNELS < 1) begin : gen_bad_cfg
    $error("angle_to_pulse_conv: SCALE_DEN must be >0 and CHANNELS >= 1");
  end

  conv_state_e state_q, state_d;

  logic [CH_W-1:0]                chan_q, chan_d;
  logic [DEG_W-1:0]               angle_q, angle_d;
  logic                           clamp_q, clamp_d;
  logic [CHANNELS-1:0][CYC_W-1:0] all_q;

  logic              over_max;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] dividend;
  logic              div_start;
  logic              div_done;
  logic [PROD_W-1:0] quotient;
  logic              sat;
  logic [CYC_W-1:0]  cycles;
  logic              commit;

  always_ff @(posedge in_Clk or negedge in_Rst) begin
    if (!in_Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_Valid) state_d = StMult;
      StMult: state_d = StDiv;
      StDiv:  if (div_done) state_d = StDone;
      StDone: if (in_Ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_Ready = (state_q == StIdle);
    out_Valid = (state_q == StDone);
    div_start = (state_q == StMult);
    commit    = (state_q == StDone) && in_Ready;
  end

  // Request capture only happens in IDLE, so later input wiggles are ignored.
  always_comb begin
    over_max = 32'(in_Degrees) > MAX_DEG;
    chan_d   = chan_q;
    angle_d  = angle_q;
    clamp_d  = clamp_q;
    if (state_q == StIdle && in_Valid) begin
      chan_d  = in_Channel;
      angle_d = over_max ? DEG_W'(MAX_DEG) : in_Degrees;
      clamp_d = over_max;
    end
  end

  always_ff @(posedge in_Clk or negedge in_Rst) begin
    if (!in_Rst) begin
      chan_q  <= '0;
      angle_q <= '0;
      clamp_q <= 1'b0;
    end else begin
      chan_q  <= chan_d;
      angle_q <= angle_d;
      clamp_q <= clamp_d;
    end
  end

  always_comb begin
    product = PROD_W'(angle_q) * PROD_W'(SCALE_NUM);
`ifdef ANGLE_CONV_ROUND_EN
    dividend = product + PROD_W'(SCALE_DEN / 2);
`else
    dividend = product;
`endif
  end

  seq_divider #(
    .WIDTH (PROD_W),
    .DIV_W (DEN_W)
  ) u_divider (
    .clk_i      (in_Clk),
    .rst_ni     (in_Rst),
    .start_i    (div_start),
    .dividend_i (dividend),
    .divisor_i  (DEN_W'(SCALE_DEN)),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  always_comb begin
    sat    = |(quotient >> CYC_W);
    cycles = sat ? '1 : CYC_W'(quotient);
  end

  // Out-of-range channel codes match no slice and so store nothing.
  always_ff @(posedge in_Clk or negedge in_Rst) begin
    if (!in_Rst) begin
      all_q <= '0;
    end else if (commit) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (chan_q == CH_W'(c)) begin
          all_q[c] <= cycles;
        end
      end
    end
  end

  assign out_Cycles     = cycles;
  assign out_Channel    = chan_q;
  assign out_Clamped    = clamp_q;
  assign out_Cycles_All = all_q;

endmodule

// File: tb/tb_angle_to_pulse_conv.sv
// Directed bench for angle_to_pulse_conv at default parameters.
module tb_angle_to_pulse_conv;

  logic        in_Clk;
  logic        in_Rst;
  logic        in_Valid;
  logic        out_Ready;
  logic [1:0]  in_Channel;
  logic [8:0]  in_Degrees;
  logic        out_Valid;
  logic        in_Ready;
  logic [1:0]  out_Channel;
  logic [9:0]  out_Cycles;
  logic        out_Clamped;
  logic [39:0] out_Cycles_All;

  int n_tests;
  int n_fail;
  int lat;

  angle_to_pulse_conv dut (
    .in_Clk         (in_Clk),
    .in_Rst         (in_Rst),
    .in_Valid       (in_Valid),
    .out_Ready      (out_Ready),
    .in_Channel     (in_Channel),
    .in_Degrees     (in_Degrees),
    .out_Valid      (out_Valid),
    .in_Ready       (in_Ready),
    .out_Channel    (out_Channel),
    .out_Cycles     (out_Cycles),
    .out_Clamped    (out_Clamped),
    .out_Cycles_All (out_Cycles_All)
  );

  initial in_Clk = 1'b0;
  always #5 in_Clk = ~in_Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request on a negedge; returns #1 after the accepting edge.
  task automatic start_req(input logic [1:0] ch, input logic [8:0] deg);
    @(negedge in_Clk);
    in_Valid   = 1'b1;
    in_Channel = ch;
    in_Degrees = deg;
    @(posedge in_Clk);
    #1;
    in_Valid   = 1'b0;
    in_Degrees = 9'h1ff;
    in_Channel = ~ch;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (out_Valid !== 1'b1 && edges < 40) begin
      @(posedge in_Clk);
      #1;
      edges++;
    end
  endtask

  task automatic take;
    @(negedge in_Clk);
    in_Ready = 1'b1;
    @(posedge in_Clk);
    #1;
    in_Ready = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    in_Rst     = 1'b0;
    in_Valid   = 1'b0;
    in_Ready   = 1'b0;
    in_Channel = '0;
    in_Degrees = '0;

    repeat (3) @(posedge in_Clk);
    @(negedge in_Clk);
    check("rst_valid", out_Valid, 0);
    check("rst_cycles", out_Cycles, 0);
    check("rst_channel", out_Channel, 0);
    check("rst_clamped", out_Clamped, 0);
    check("rst_all", out_Cycles_All, 0);
    in_Rst = 1'b1;
    @(posedge in_Clk);
    #1;
    check("ready_after_rst", out_Ready, 1);

    // Channel 2, 90 degrees, with a 5-cycle downstream stall.
    start_req(2'd2, 9'd90);
    check("busy_not_ready", out_Ready, 0);
    wait_valid(lat);
    check("lat_90", lat, 14);
    check("cyc_90", out_Cycles, 50);
    check("ch_90", out_Channel, 2);
    check("clamp_90", out_Clamped, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge in_Clk);
      #1;
      check("hold_valid", out_Valid, 1);
      check("hold_cycles", out_Cycles, 50);
      check("hold_ready", out_Ready, 0);
    end
    check("all_before_take", out_Cycles_All, 0);

    // Request offered in the same cycle as the DONE handshake.
    @(negedge in_Clk);
    in_Ready   = 1'b1;
    in_Valid   = 1'b1;
    in_Channel = 2'd1;
    in_Degrees = 9'd180;
    @(posedge in_Clk);
    #1;
    in_Ready = 1'b0;
    check("handshake_valid", out_Valid, 0);
    check("handshake_ready", out_Ready, 1);
    check("all_slice2", out_Cycles_All, 40'd50 << 20);
    @(posedge in_Clk);
    #1;
    in_Valid   = 1'b0;
    in_Degrees = 9'h1ff;
    check("late_accept", out_Ready, 0);
    wait_valid(lat);
    check("lat_180", lat, 14);
    check("cyc_180", out_Cycles, 100);
    check("ch_180", out_Channel, 1);
    check("clamp_180", out_Clamped, 0);
    take();
    check("all_slice1", out_Cycles_All, (40'd50 << 20) | (40'd100 << 10));

    start_req(2'd3, 9'd200);
    wait_valid(lat);
    check("cyc_200", out_Cycles, 100);
    check("clamp_200", out_Clamped, 1);
    check("ch_200", out_Channel, 3);
    take();

    start_req(2'd0, 9'd19);
    wait_valid(lat);
`ifdef ANGLE_CONV_ROUND_EN
    check("cyc_19", out_Cycles, 11);
`else
    check("cyc_19", out_Cycles, 10);
`endif
    take();

    start_req(2'd0, 9'd1);
    wait_valid(lat);
`ifdef ANGLE_CONV_ROUND_EN
    check("cyc_1", out_Cycles, 1);
`else
    check("cyc_1", out_Cycles, 0);
`endif
    take();

    // Clean reset, then abort an operation mid-division.
    @(negedge in_Clk);
    in_Rst = 1'b0;
    @(negedge in_Clk);
    check("rst2_all", out_Cycles_All, 0);
    in_Rst = 1'b1;
    start_req(2'd1, 9'd100);
    repeat (7) @(posedge in_Clk);
    #1;
    in_Rst = 1'b0;
    #1;
    check("abort_ready", out_Ready, 1);
    check("abort_valid", out_Valid, 0);
    check("abort_cycles", out_Cycles, 0);
    check("abort_channel", out_Channel, 0);
    check("abort_all", out_Cycles_All, 0);
    @(negedge in_Clk);
    in_Rst = 1'b1;
    repeat (20) @(posedge in_Clk);
    #1;
    check("abort_no_result", out_Valid, 0);
    check("abort_all_later", out_Cycles_All, 0);

    // Back-to-back fill of every channel.
    for (int c = 0; c < 4; c++) begin
      start_req(2'(c), 9'(45 * (c + 1)));
      wait_valid(lat);
      check("b2b_lat", lat, 14);
      check("b2b_cycles", out_Cycles, 64'(25 * (c + 1)));
      take();
    end
    check("b2b_all", out_Cycles_All, {10'd100, 10'd75, 10'd50, 10'd25});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/angle_to_pulse_conv.md
ANGLE_TO_PULSE_CONV -- requirements
Module: angle_to_pulse_conv

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  CHANNELS, 4, number of servo channels
  DEG_W, 9, angle input width
  CYC_W, 10, cycle-count output width
  SCALE_NUM, 10, multiplier constant
  SCALE_DEN, 18, divisor constant, >0
  MAX_DEG, 180, clamp limit
REQ-002 SHALL have ports (name, direction, width, meaning):
  in_Clk  in  1  single clock, rising edge
  in_Rst  in  1  asynchronous, active-low reset
  in_Valid  in  1  request strobe
  out_Ready  out  1  converter accepts a request
  in_Channel  in  $clog2(CHANNELS)  target channel
  in_Degrees  in  DEG_W  angle
  out_Valid  out  1  result available
  in_Ready  in  1  downstream takes result
  out_Channel  out  $clog2(CHANNELS)  channel of result
  out_Cycles  out  CYC_W  converted count
  out_Clamped  out  1  input exceeded MAX_DEG
  out_Cycles_All  out  CHANNELS*CYC_W  last result per channel, channel 0 in LSBs

Function
REQ-003 SHALL compute out_Cycles = floor(min(in_Degrees,MAX_DEG)*SCALE_NUM/SCALE_DEN), saturated to all-ones if wider than CYC_W.
REQ-004 SHALL use product width PROD_W = DEG_W + $clog2(SCALE_NUM+1) (13 at defaults).
REQ-005 SHALL implement FSM IDLE -> MULT -> DIV -> DONE -> IDLE.
REQ-006 out_Ready SHALL be 1 only in IDLE; a request is accepted on an edge with in_Valid=1 in IDLE, latching in_Channel, clamped angle and clamp flag; state -> MULT.
REQ-007 MULT SHALL take one cycle, latching the product; state -> DIV with bit counter = PROD_W-1.
REQ-008 DIV SHALL be restoring division, one quotient bit per cycle, PROD_W cycles; on final bit state -> DONE.
REQ-009 out_Valid SHALL rise PROD_W+1 edges after the accepting edge (14 at defaults) and be 1 only in DONE.
REQ-010 In DONE, out_Cycles/out_Channel/out_Clamped SHALL remain stable until in_Ready=1; that edge returns to IDLE.
REQ-011 On DONE->IDLE transition, out_Cycles_All slice [out_Channel] SHALL be updated; other slices unchanged.
REQ-012 in_Valid=1 in the same cycle as DONE with in_Ready=1 SHALL NOT be accepted (out_Ready=0); accepted next cycle if held.
REQ-013 in_Valid/in_Degrees changes outside IDLE SHALL have no effect.
REQ-014 in_Channel >= CHANNELS SHALL be taken modulo 2^width and write no slice if out of range.

Reset
REQ-015 in_Rst=0 SHALL asynchronously force IDLE; out_Valid=0, out_Cycles=0, out_Channel=0, out_Clamped=0, out_Cycles_All=0, counter and datapath zero.
REQ-016 Reset mid-MULT/DIV/DONE SHALL discard the operation; no slice update.
REQ-017 out_Ready SHALL be 1 on the first edge after reset deassertion.

Configuration
REQ-018 With macro ANGLE_CONV_ROUND_EN defined, the product SHALL be incremented by floor(SCALE_DEN/2) before division (round-half-up); latency unchanged.
REQ-019 Without ANGLE_CONV_ROUND_EN, result SHALL be truncated (REQ-003).

Structure
REQ-020 Package angle_conv_pkg SHALL hold the FSM state enum and the PROD_W width function.
REQ-021 Division SHALL be a sub-module seq_divider (start/done, parametric width), instantiated once.
REQ-022 Elaboration SHALL fail if SCALE_DEN=0 or CHANNELS<1.

Verification (defaults)
REQ-023 Reset then channel 2, 90 deg -> out_Valid 14 edges after accept, out_Cycles=50, out_Channel=2, slice 2=50 after in_Ready.
REQ-024 180 deg -> 100; 200 deg -> 100, out_Clamped=1.
REQ-025 19 deg -> 10 truncate, 11 with ANGLE_CONV_ROUND_EN; 1 deg -> 0 / 1.
REQ-026 Hold in_Ready=0 for 5 cycles in DONE -> outputs stable, out_Ready=0; in_Valid with in_Ready same cycle -> accepted one cycle later.
REQ-027 Assert in_Rst=0 in DIV cycle 6 -> immediate IDLE, all outputs 0, out_Cycles_All unchanged from zero.
REQ-028 Back-to-back channels 0..3 with 45,90,135,180 -> out_Cycles_All = {100,75,50,25}.
